// File: rtl/mprjram_arbiter_pkg.sv
// Shared types and helpers for the mprjram two-master Wishbone arbiter.
package mprjram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3800_0000;

   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int unsigned addr_w);
      return (adr >> addr_w) == (base >> addr_w);
   endfunction

endpackage

// File: rtl/mprjram_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the SDRAM controller.
interface mprjram_arbiter_if #(parameter int ADDR_W = 22);

   logic              m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]        m0_sel_i;
   logic [31:0]       m0_adr_i, m0_dat_i, m0_dat_o;
   logic              m0_ack_o, m0_err_o;

   logic              m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]        m1_sel_i;
   logic [31:0]       m1_adr_i, m1_dat_i, m1_dat_o;
   logic              m1_ack_o, m1_err_o;

   logic              c_valid_o, c_ready_i, c_we_o;
   logic [3:0]        c_sel_o;
   logic [ADDR_W-3:0] c_addr_o;
   logic [31:0]       c_wdata_o;
   logic              c_rvalid_i;
   logic [31:0]       c_rdata_i;

   // Arbiter side
   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      output m0_dat_o, m0_ack_o, m0_err_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      output m1_dat_o, m1_ack_o, m1_err_o,
      output c_valid_o, c_we_o, c_sel_o, c_addr_o, c_wdata_o,
      input  c_ready_i, c_rvalid_i, c_rdata_i
   );

   // Environment side (masters plus controller)
   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      input  m0_dat_o, m0_ack_o, m0_err_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      input  m1_dat_o, m1_ack_o, m1_err_o,
      input  c_valid_o, c_we_o, c_sel_o, c_addr_o, c_wdata_o,
      output c_ready_i, c_rvalid_i, c_rdata_i
   );

endinterface

// File: rtl/mprjram_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; on a tie the master not granted last wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       valid
);

   logic last_grant;

   always_comb begin
      valid = |req;
      if (req == 2'b11) grant = ~last_grant;
      else              grant = req[1];
   end

   // Starts at 1 so master 0 takes the first tie after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      last_grant <= 1'b1;
      else if (update) last_grant <= grant;
   end

endmodule

// File: rtl/mprjram_arbiter.sv
// Round-robin Wishbone arbiter in front of the mprjram SDRAM controller with a
// single outstanding request, read timeout and stale-return suppression.
module mprjram_arbiter
   import mprjram_arb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
   parameter int          ADDR_W    = 22,
   parameter int          TIMEOUT   = 1024
) (
   input logic              wb_clk_i,
   input logic              rst_n,
   mprjram_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e       state;
   logic             stale;
   logic [CNT_W-1:0] cnt;
   logic             gnt_q;
   logic [1:0]       ack_q, err_q;
   logic [31:0]      rdata_q;

   logic [1:0]  cyc, req;
   logic        arb_gnt, arb_valid, arb_update;
   logic        sel_we;
   logic [3:0]  sel_sel;
   logic [31:0] sel_adr, sel_dat;

   assign cyc = {bus.m1_cyc_i, bus.m0_cyc_i};
   assign req = cyc & {bus.m1_stb_i, bus.m0_stb_i};

   // While a timed-out read may still return, no new transfer is started
   assign arb_update = (state == IDLE) && !stale && arb_valid;

   rr_arb2 u_arb (
      .clk    (wb_clk_i),
      .rst_n  (rst_n),
      .req    (req),
      .update (arb_update),
      .grant  (arb_gnt),
      .valid  (arb_valid)
   );

   always_comb begin
      if (arb_gnt) begin
         sel_we  = bus.m1_we_i;
         sel_sel = bus.m1_sel_i;
         sel_adr = bus.m1_adr_i;
         sel_dat = bus.m1_dat_i;
      end else begin
         sel_we  = bus.m0_we_i;
         sel_sel = bus.m0_sel_i;
         sel_adr = bus.m0_adr_i;
         sel_dat = bus.m0_dat_i;
      end
   end

   // Responses are only delivered if the winner still holds cyc when the
   // transfer completes; otherwise they are dropped.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         stale         <= 1'b0;
         cnt           <= '0;
         gnt_q         <= 1'b0;
         ack_q         <= '0;
         err_q         <= '0;
         rdata_q       <= '0;
         bus.c_valid_o <= 1'b0;
         bus.c_we_o    <= 1'b0;
         bus.c_sel_o   <= '0;
         bus.c_addr_o  <= '0;
         bus.c_wdata_o <= '0;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         if (stale && bus.c_rvalid_i) stale <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_update) begin
                  gnt_q <= arb_gnt;
                  if (in_window(sel_adr, BASE_ADDR, ADDR_W)) begin
                     bus.c_valid_o <= 1'b1;
                     bus.c_we_o    <= sel_we;
                     bus.c_sel_o   <= sel_sel;
                     bus.c_addr_o  <= sel_adr[ADDR_W-1:2];
                     bus.c_wdata_o <= sel_dat;
                     state         <= ISSUE;
                  end else begin
                     err_q[arb_gnt] <= 1'b1;
                     state          <= RESP;
                  end
               end
            end
            ISSUE: begin
               if (bus.c_ready_i) begin
                  bus.c_valid_o <= 1'b0;
                  if (bus.c_we_o) begin
                     ack_q[gnt_q] <= cyc[gnt_q];
                     state        <= RESP;
                  end else begin
                     cnt   <= CNT_W'(TIMEOUT);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Data arriving on the expiry cycle still wins over the timeout
               if (bus.c_rvalid_i) begin
                  rdata_q      <= bus.c_rdata_i;
                  ack_q[gnt_q] <= cyc[gnt_q];
                  cnt          <= '0;
                  state        <= RESP;
               end else if (cnt == CNT_W'(1)) begin
                  err_q[gnt_q] <= cyc[gnt_q];
                  stale        <= 1'b1;
                  cnt          <= '0;
                  state        <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m0_ack_o = ack_q[0];
   assign bus.m1_ack_o = ack_q[1];
   assign bus.m0_err_o = err_q[0];
   assign bus.m1_err_o = err_q[1];
   assign bus.m0_dat_o = (gnt_q == 1'b0) ? rdata_q : 32'h0;
   assign bus.m1_dat_o = (gnt_q == 1'b1) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mprjram_arbiter.sv
// Self-checking bench for mprjram_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mprjram_arbiter;

   localparam int          ADDR_W  = 22;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] BASE    = 32'h3800_0000;

   logic wb_clk_i = 1'b0;
   logic rst_n    = 1'b0;

   initial forever #5 wb_clk_i = ~wb_clk_i;

   mprjram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mprjram_arbiter #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i (wb_clk_i),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level picture of the arbiter
   bit          m_busy, m_offered, m_waiting, m_respond, m_stale, m_last, m_we;
   int          m_owner, m_waited;
   logic [3:0]  m_sel;
   logic [31:0] m_addr, m_wdata, m_rdata;
   bit   [1:0]  m_ack, m_err;

   bit hs_last;
   int rsp_cnt;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit inWin(input logic [31:0] a);
      return (a >> ADDR_W) == (BASE >> ADDR_W);
   endfunction

   task automatic modelReset();
      m_busy = 0; m_offered = 0; m_waiting = 0; m_respond = 0; m_stale = 0;
      m_last = 1; m_we = 0; m_owner = 0; m_waited = 0;
      m_sel = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_ack = '0; m_err = '0;
   endtask

   // Predict what the arbiter does at the coming clock edge
   task automatic modelStep();
      bit [1:0] cyc, req;
      bit was_stale;
      int w;
      if (!rst_n) begin
         modelReset();
         return;
      end
      cyc = {bus.m1_cyc_i, bus.m0_cyc_i};
      req = cyc & {bus.m1_stb_i, bus.m0_stb_i};
      was_stale = m_stale;
      m_ack = '0;
      m_err = '0;
      if (m_stale && bus.c_rvalid_i) m_stale = 0;
      if (m_respond) begin
         m_respond = 0;
         m_busy = 0;
      end else if (!m_busy) begin
         if (!was_stale && req != 2'b00) begin
            if (req == 2'b11) w = m_last ? 0 : 1;
            else              w = req[1] ? 1 : 0;
            m_last  = (w == 1);
            m_owner = w;
            m_busy  = 1;
            m_we    = (w == 1) ? bus.m1_we_i  : bus.m0_we_i;
            m_sel   = (w == 1) ? bus.m1_sel_i : bus.m0_sel_i;
            m_addr  = (w == 1) ? bus.m1_adr_i : bus.m0_adr_i;
            m_wdata = (w == 1) ? bus.m1_dat_i : bus.m0_dat_i;
            if (inWin(m_addr)) m_offered = 1;
            else begin
               m_err[w]  = 1;
               m_respond = 1;
            end
         end
      end else if (m_offered) begin
         if (bus.c_ready_i) begin
            m_offered = 0;
            if (m_we) begin
               m_ack[m_owner] = cyc[m_owner];
               m_respond = 1;
            end else begin
               m_waiting = 1;
               m_waited  = 0;
            end
         end
      end else if (m_waiting) begin
         m_waited++;
         if (bus.c_rvalid_i) begin
            m_rdata = bus.c_rdata_i;
            m_ack[m_owner] = cyc[m_owner];
            m_respond = 1;
            m_waiting = 0;
         end else if (m_waited == TIMEOUT) begin
            m_err[m_owner] = cyc[m_owner];
            m_stale   = 1;
            m_respond = 1;
            m_waiting = 0;
         end
      end
   endtask

   task automatic checkOutput();
      checkBit("c_valid", bus.c_valid_o, m_offered);
      if (m_offered) begin
         checkBit("c_we", bus.c_we_o, m_we);
         checkVal("c_sel", 32'(bus.c_sel_o), 32'(m_sel));
         checkVal("c_addr", 32'(bus.c_addr_o), 32'(m_addr[ADDR_W-1:2]));
         checkVal("c_wdata", bus.c_wdata_o, m_wdata);
      end
      checkBit("m0_ack", bus.m0_ack_o, m_ack[0]);
      checkBit("m0_err", bus.m0_err_o, m_err[0]);
      checkBit("m1_ack", bus.m1_ack_o, m_ack[1]);
      checkBit("m1_err", bus.m1_err_o, m_err[1]);
      checkVal("m0_dat", bus.m0_dat_o, (m_owner == 0) ? m_rdata : 32'h0);
      checkVal("m1_dat", bus.m1_dat_o, (m_owner == 1) ? m_rdata : 32'h0);
   endtask

   task automatic tick();
      hs_last = bus.c_valid_o && bus.c_ready_i && !bus.c_we_o;
      modelStep();
      @(posedge wb_clk_i);
      #2;
      checkOutput();
   endtask

   task automatic setMaster(input int n, input bit cyc, input bit stb, input bit we,
                            input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      if (n == 0) begin
         bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we;
         bus.m0_sel_i = sel; bus.m0_adr_i = adr; bus.m0_dat_i = dat;
      end else begin
         bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we;
         bus.m1_sel_i = sel; bus.m1_adr_i = adr; bus.m1_dat_i = dat;
      end
   endtask

   task automatic setIdle();
      setMaster(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      setMaster(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
      bus.c_ready_i  = 0;
      bus.c_rvalid_i = 0;
      bus.c_rdata_i  = 32'h0;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
   task automatic doReset();
      #3 rst_n = 0;
      #1;
      modelReset();
      checkOutput();
      checkBit("rst_c_valid", bus.c_valid_o, 1'b0);
      checkBit("rst_c_we", bus.c_we_o, 1'b0);
      checkVal("rst_c_addr", 32'(bus.c_addr_o), 32'h0);
      checkVal("rst_c_wdata", bus.c_wdata_o, 32'h0);
      checkBit("rst_m0_ack", bus.m0_ack_o, 1'b0);
      checkBit("rst_m1_err", bus.m1_err_o, 1'b0);
      checkVal("rst_m0_dat", bus.m0_dat_o, 32'h0);
      checkVal("rst_m1_dat", bus.m1_dat_o, 32'h0);
      setIdle();
      rsp_cnt = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   function automatic int pickDelay();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      return $urandom_range(1, 8);
      else if (r < 9) return $urandom_range(14, 18);
      else            return $urandom_range(19, 30);
   endfunction

   task automatic newReq(input int n);
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) begin
         a = $urandom;
         if (inWin(a)) a = a ^ 32'h8000_0000;
      end else begin
         a = BASE | ($urandom & 32'h003F_FFFF);
      end
      setMaster(n, 1, 1, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
   endtask

   task automatic applyStimulus();
      bit c;
      if (hs_last) rsp_cnt = pickDelay();
      if (rsp_cnt > 0) begin
         bus.c_rvalid_i = (rsp_cnt == 1);
         rsp_cnt--;
      end else begin
         bus.c_rvalid_i = ($urandom_range(0, 63) == 0);
      end
      bus.c_rdata_i = $urandom;
      bus.c_ready_i = 1'($urandom_range(0, 1));
      for (int n = 0; n < 2; n++) begin
         c = (n == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
         if (c) begin
            if (m_ack[n] || m_err[n]) begin
               if ($urandom_range(0, 1) == 1) newReq(n);
               else setMaster(n, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            end else if ($urandom_range(0, 99) == 0) begin
               setMaster(n, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            newReq(n);
         end
      end
   endtask

   initial begin
      int n, winner;
      rst_n = 0;
      setIdle();
      modelReset();
      hs_last = 0;
      rsp_cnt = 0;
      tick();
      tick();
      checkBit("init_c_valid", bus.c_valid_o, 1'b0);
      checkBit("init_m0_ack", bus.m0_ack_o, 1'b0);
      rst_n = 1;
      tick();

      $display("[TB] single write from m0");
      setMaster(0, 1, 1, 1, 4'hF, 32'h3800_0010, 32'h1234_5678);
      bus.c_ready_i = 1;
      tick();
      checkBit("wr_c_valid", bus.c_valid_o, 1'b1);
      checkVal("wr_c_addr", 32'(bus.c_addr_o), 32'd4);
      checkBit("wr_c_we", bus.c_we_o, 1'b1);
      checkVal("wr_c_wdata", bus.c_wdata_o, 32'h1234_5678);
      checkBit("wr_early_ack", bus.m0_ack_o, 1'b0);
      tick();
      checkBit("wr_ack", bus.m0_ack_o, 1'b1);
      checkBit("wr_c_valid_done", bus.c_valid_o, 1'b0);
      setIdle();
      tick();
      checkBit("wr_ack_once", bus.m0_ack_o, 1'b0);

      $display("[TB] single read from m1");
      setMaster(1, 1, 1, 0, 4'hF, 32'h3800_0020, 32'h0);
      bus.c_ready_i = 1;
      tick();
      checkVal("rd_c_addr", 32'(bus.c_addr_o), 32'd8);
      tick();
      bus.c_ready_i = 0;
      tick();
      tick();
      checkBit("rd_early_ack", bus.m1_ack_o, 1'b0);
      bus.c_rvalid_i = 1;
      bus.c_rdata_i  = 32'hAB50_0000;
      tick();
      bus.c_rvalid_i = 0;
      checkBit("rd_ack", bus.m1_ack_o, 1'b1);
      checkVal("rd_dat", bus.m1_dat_o, 32'hAB50_0000);
      checkBit("rd_m0_ack", bus.m0_ack_o, 1'b0);
      checkVal("rd_m0_dat", bus.m0_dat_o, 32'h0);
      setIdle();
      tick();

      $display("[TB] out-of-window access from m0");
      setMaster(0, 1, 1, 0, 4'hF, 32'h3000_0000, 32'h0);
      tick();
      checkBit("oow_err", bus.m0_err_o, 1'b1);
      checkBit("oow_c_valid", bus.c_valid_o, 1'b0);
      setIdle();
      tick();
      checkBit("oow_c_valid_after", bus.c_valid_o, 1'b0);

      $display("[TB] contention after reset");
      doReset();
      tick();
      setMaster(0, 1, 1, 0, 4'hF, 32'h3800_0100, 32'h0);
      setMaster(1, 1, 1, 0, 4'hF, 32'h3800_0200, 32'h0);
      bus.c_ready_i = 1;
      n = 0;
      for (int i = 0; i < 200 && n < 8; i++) begin
         bus.c_rvalid_i = hs_last;
         bus.c_rdata_i  = $urandom;
         tick();
         if (bus.m0_ack_o || bus.m1_ack_o) begin
            winner = bus.m1_ack_o ? 1 : 0;
            checkVal($sformatf("cont_grant%0d", n), winner, n % 2);
            n++;
         end
      end
      checkVal("cont_count", n, 8);
      setIdle();
      tick();

      $display("[TB] read timeout and stale return");
      setMaster(0, 1, 1, 0, 4'hF, 32'h3800_0040, 32'h0);
      bus.c_ready_i = 1;
      tick();
      tick();
      bus.c_ready_i = 0;
      for (int k = 2; k <= TIMEOUT; k++) begin
         tick();
         checkBit("to_early_err", bus.m0_err_o, 1'b0);
      end
      tick();
      checkBit("to_err", bus.m0_err_o, 1'b1);
      checkBit("to_ack", bus.m0_ack_o, 1'b0);
      setIdle();
      setMaster(1, 1, 1, 0, 4'hF, 32'h3800_0080, 32'h0);
      bus.c_ready_i = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checkBit("stale_block", bus.c_valid_o, 1'b0);
      end
      bus.c_rvalid_i = 1;
      bus.c_rdata_i  = 32'hDEAD_BEEF;
      tick();
      bus.c_rvalid_i = 0;
      checkBit("stale_swallow", bus.c_valid_o, 1'b0);
      checkBit("stale_no_ack", bus.m1_ack_o, 1'b0);
      tick();
      checkBit("stale_issue", bus.c_valid_o, 1'b1);
      checkVal("stale_addr", 32'(bus.c_addr_o), 32'h20);
      tick();
      bus.c_rvalid_i = 1;
      bus.c_rdata_i  = 32'h0000_1111;
      tick();
      bus.c_rvalid_i = 0;
      checkBit("late_ack", bus.m1_ack_o, 1'b1);
      checkVal("late_dat", bus.m1_dat_o, 32'h0000_1111);
      setIdle();
      tick();

      $display("[TB] reset during WAIT");
      setMaster(0, 1, 1, 0, 4'hF, 32'h3800_0004, 32'h0);
      bus.c_ready_i = 1;
      tick();
      tick();
      bus.c_ready_i = 0;
      tick();
      doReset();
      tick();
      setMaster(0, 1, 1, 1, 4'h3, 32'h3800_0008, 32'hCAFE_F00D);
      bus.c_ready_i = 1;
      tick();
      checkBit("post_rst_c_valid", bus.c_valid_o, 1'b1);
      checkVal("post_rst_c_wdata", bus.c_wdata_o, 32'hCAFE_F00D);
      tick();
      checkBit("post_rst_ack", bus.m0_ack_o, 1'b1);
      setIdle();
      tick();

      $display("[TB] m1 abandons a read");
      setMaster(1, 1, 1, 0, 4'hF, 32'h3800_000C, 32'h0);
      bus.c_ready_i = 1;
      tick();
      tick();
      bus.c_ready_i = 0;
      setMaster(1, 0, 0, 0, 4'hF, 32'h3800_000C, 32'h0);
      tick();
      bus.c_rvalid_i = 1;
      bus.c_rdata_i  = 32'h5555_5555;
      tick();
      bus.c_rvalid_i = 0;
      checkBit("abort_ack", bus.m1_ack_o, 1'b0);
      checkBit("abort_err", bus.m1_err_o, 1'b0);
      tick();

      $display("[TB] random traffic");
      setIdle();
      rsp_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         applyStimulus();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mprjram_arbiter.md
# mprjram_arbiter

Two-master Wishbone arbiter in front of the user-project SDRAM controller that backs the mprjram window (0x3800_0000). Master 0 is the management-core Wishbone slave port (instruction fetch and data of code such as `matmul()` running from mprjram). Master 1 is the LA-driven DMA requester. The block selects one master per transfer round-robin, issues a single outstanding request to the controller, and routes read data, ack and error back to the winner. It also enforces a read-response timeout.

## Interface
Parameters:
- BASE_ADDR, 32'h3800_0000, byte base of the mprjram window
- ADDR_W, 22, window size in byte-address bits (4 MiB)
- TIMEOUT, 1024, maximum cycles to wait for read data before erroring

Ports:
- wb_clk_i  in  1  clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- mN_cyc_i, mN_stb_i, mN_we_i (N=0,1)  in  1 each  Wishbone classic request from master N
- mN_sel_i  in  4  byte enables
- mN_adr_i  in  32  byte address
- mN_dat_i  in  32  write data
- mN_dat_o  out  32  read data, valid with ack
- mN_ack_o  out  1  one-cycle transfer-complete pulse
- mN_err_o  out  1  one-cycle error pulse
- c_valid_o  out  1  request to controller
- c_ready_i  in  1  controller accepts request
- c_we_o  out  1, c_sel_o out 4, c_addr_o out ADDR_W-2 (word address), c_wdata_o out 32
- c_rvalid_i  in  1, c_rdata_i in 32  read return

## Operation
- A request from master N is `cyc&stb`. It is in-window when `adr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate among requesting masters.
  - If exactly one master requests, it wins.
  - If both request, the master not granted last wins.
  - `last_grant` resets to 1, so master 0 wins the first tie.
  - The grant and request fields (we, sel, word address, wdata) are latched.
  - An out-of-window request goes to RESP with err set and never reaches the controller.
- ISSUE: drive c_valid_o and hold all c_* fields stable until c_ready_i.
  - On handshake with a write: go to RESP.
  - On handshake with a read: go to WAIT.
- WAIT: on c_rvalid_i, latch c_rdata_i and go to RESP.
  - A down-counter loaded with TIMEOUT decrements each cycle.
  - At 0: go to RESP with err set, and set the `stale` flag.
- RESP: for one cycle, pulse ack (or err) to the granted master, provided its cyc_i is still high; then return to IDLE.
  - If cyc dropped mid-transfer, the controller transaction still completes and the response is silently discarded.
- stale handling:
  - While stale=1, IDLE does not arbitrate.
  - The next c_rvalid_i is swallowed and clears stale.
  - This prevents a late return from aliasing a new read.
- mN_dat_o holds the last read data for the granted master and is 0 for the other master.
- Reset (at any time, including mid-ISSUE/WAIT):
  - FSM to IDLE, stale=0, counter=0.
  - All outputs 0.
  - No controller handshake is completed.

## Timing
- Write, c_ready_i high on first offer: request seen in IDLE at cycle t, c_valid_o at t+1, ack at t+2. Three cycles from stb to ack.
- Read: ack one cycle after c_rvalid_i. Minimum latency is four cycles with rvalid the cycle after the handshake.
- Out-of-window: err at t+1.
- Back-to-back: the cycle after RESP is IDLE, so a master holding stb for a new transfer is re-arbitrated there. With both masters active, grants strictly alternate.
- c_rvalid_i asserted outside WAIT with stale=0: ignored (protocol error at the controller).
- c_rvalid_i in the same cycle as counter expiry: data is accepted, no error, stale stays 0.
- ack and err are never asserted together, and never to both masters in the same cycle.

## Structure
- Package `mprjram_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - the BASE_ADDR default
  - the `in_window` function
- Sub-module `rr_arb2`: two-request round-robin arbiter with a `last_grant` register. Its grant is updated only on the IDLE->ISSUE/RESP transition.
- Top: FSM, request latch, timeout counter, stale flag, response mux.

## Test plan
- Write: m0 writes 0x1234_5678, sel=4'hF, adr 0x3800_0010 → one c_valid handshake with c_addr=4, c_we=1; m0 ack exactly 2 cycles after the request is seen.
- Read: m1 reads 0x3800_0020, controller returns 0xAB50_0000 three cycles after the handshake → m1_dat_o=0xAB50_0000 with ack; m0 sees no ack.
- Contention: both masters hold back-to-back reads for 8 transfers → grants alternate 0,1,0,1…, starting with m0 after reset.
- Out-of-window: m0 accesses 0x3000_0000 → m0_err one cycle later; c_valid_o stays 0.
- Timeout: TIMEOUT=16, controller never answers a read → err at cycle 16 of WAIT. A new m1 request is blocked until a late c_rvalid arrives; that data is dropped and the m1 request is then issued.
- Reset and abort:
  - rst_n pulled low during WAIT → all outputs 0 immediately; after release, a fresh m0 write completes normally.
  - m1 drops cyc during WAIT → no ack is issued.
